// File: rtl/seg7_scan_driver_if.sv
// Host write port of the seven-segment scan driver.
// The wr_dp lane is present only when SEG7_DP_EN is defined.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [3:0]       wr_data;
`ifdef SEG7_DP_EN
  logic             wr_dp;
`endif
  logic             wr_ack;

  modport master (
    output wr_en, wr_addr, wr_data,
`ifdef SEG7_DP_EN
    output wr_dp,
`endif
    input  wr_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
`ifdef SEG7_DP_EN
    input  wr_dp,
`endif
    output wr_ack
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment driver.
// One 4-bit value per digit is written through the host port. Digits are scanned
// one at a time, each held for REFRESH_DIV clocks. Segments and anodes are active-low.
// Optional decimal point storage/output: define SEG7_DP_EN.
module seg7_scan_driver #(
  parameter  int NUM_DIGITS  = 8,
  parameter  int REFRESH_DIV = 100000,
  localparam int IDX_W       = $clog2(NUM_DIGITS),
  localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_driver_if.slave     wr_bus,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic                  seg_a,
  output logic                  seg_b,
  output logic                  seg_c,
  output logic                  seg_d,
  output logic                  seg_e,
  output logic                  seg_f,
  output logic                  seg_g,
`ifdef SEG7_DP_EN
  output logic                  seg_dp,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W+1)'(NUM_DIGITS);

  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0][3:0] dig_q;
  logic                       cnt_tc;
  logic                       wr_ok;
  logic [NUM_DIGITS-1:0]      sel_oh;
  logic [6:0]                 seg_dec;
  logic                       blank;
  logic [6:0]                 seg_q;    // {g,f,e,d,c,b,a}, active-low
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]      dp_q;
`endif

  // Active-high gfedcba pattern for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign cnt_tc = (cnt == CNT_TC);
  // Out-of-range addresses are dropped silently (no store, no ack).
  assign wr_ok  = wr_bus.wr_en && ({1'b0, wr_bus.wr_addr} < IDX_LIM);

  // Scan timebase: hold each digit REFRESH_DIV clocks, then step to the next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_tc) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit register file; writes are independent of the scan position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q <= '0;
`ifdef SEG7_DP_EN
      dp_q  <= '0;
`endif
    end else if (wr_ok) begin
      dig_q[wr_bus.wr_addr] <= wr_bus.wr_data;
`ifdef SEG7_DP_EN
      dp_q[wr_bus.wr_addr]  <= wr_bus.wr_dp;
`endif
    end
  end

  // Select and decode the digit under the scan pointer.
  always_comb begin
    sel_oh      = '0;
    sel_oh[idx] = 1'b1;
    seg_dec     = hex7(dig_q[idx]);
    blank       = !digit_en[idx];
  end

  // Registered pin drivers; a blanked slot keeps its time but lights nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an            <= '1;
      seg_q         <= '1;
      frame_tick    <= 1'b0;
      wr_bus.wr_ack <= 1'b0;
`ifdef SEG7_DP_EN
      seg_dp        <= 1'b1;
`endif
    end else begin
      an            <= blank ? '1 : ~sel_oh;
      seg_q         <= blank ? '1 : ~seg_dec;
      frame_tick    <= cnt_tc && (idx == IDX_LAST);
      wr_bus.wr_ack <= wr_ok;
`ifdef SEG7_DP_EN
      seg_dp        <= blank ? 1'b1 : ~dp_q[idx];
`endif
    end
  end

  assign {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = seg_q;

endmodule
